pll_reconfig_seq: RTL and testbench

Master-side sequencer that drives the PLL reconfiguration management bus (mgmt_* Avalon-MM style, consumed by pll_cfg).
- Host logic queues (address, data) register writes into an internal FIFO, then pulses cmd_go.
- The block then performs, in order: a mode write, all queued writes, and the start write.
- It then waits for PLL relock and reports done or timeout.
- Sits between the video-mode/config register block and pll_cfg, all in the mgmt_clk domain.

---
 rtl/pll_reconfig_pkg.sv | 26 ++
 rtl/pll_cmd_fifo.sv | 59 +++++
 rtl/pll_reconfig_seq.sv | 169 ++++++++++++++++
 tb/tb_pll_reconfig_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reconfig_pkg.sv
// Shared types and constants for the PLL reconfiguration sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package pll_reconfig_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MODE,
        ST_DRAIN,
        ST_START,
        ST_HOLDOFF,
        ST_LOCKWAIT
    } state_t;

    // Mode register written with 0 selects waitrequest mode in pll_cfg.
    localparam logic [5:0]  DEF_MODE_ADDR  = 6'h00;
    localparam logic [5:0]  DEF_START_ADDR = 6'h02;
    localparam logic [31:0] MODE_DATA      = 32'd0;
    localparam logic [31:0] START_DATA     = 32'd1;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } entry_t;

endpackage

// File: rtl/pll_cmd_fifo.sv
// Synchronous FIFO of queued PLL register writes.
// Latency: push visible at head the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: push/push_entry write side, pop/head read side, full/empty/one_left status.
module pll_cmd_fifo
    import pll_reconfig_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_entry,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty,
    output logic   one_left
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           do_push;
    logic           do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign one_left = (count == CW'(1));
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two so the pointers wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/pll_reconfig_seq.sv
// Sequences mode write, queued writes and start write onto the PLL mgmt bus, then waits for relock.
// Latency: go -> done = N+2 write cycles + LOCK_HOLDOFF + LOCK_STABLE + 1 with no stalls.
// Backpressure: mgmt_waitrequest holds the current write; cmd_ready low when full or sequencing.
// Ports: cmd_* host queue/commit, busy/done/error status, mgmt_* bus master, pll_locked lock input.
module pll_reconfig_seq
    import pll_reconfig_pkg::*;
#(
    parameter int         FIFO_DEPTH   = 16,
    parameter logic [5:0] MODE_ADDR    = DEF_MODE_ADDR,
    parameter logic [5:0] START_ADDR   = DEF_START_ADDR,
    parameter int         LOCK_HOLDOFF = 64,
    parameter int         LOCK_STABLE  = 16,
    parameter int         LOCK_TIMEOUT = 65536
) (
    input  logic        mgmt_clk,
    input  logic        mgmt_reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic        cmd_go,
    output logic        busy,
    output logic        done,
    output logic        error,
    input  logic        mgmt_waitrequest,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    input  logic        pll_locked
);

    localparam int HW = $clog2(LOCK_HOLDOFF + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [HW-1:0] HOLD_MAX    = HW'(LOCK_HOLDOFF);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(LOCK_HOLDOFF - 1);
    localparam logic [SW-1:0] STABLE_MAX  = SW'(LOCK_STABLE);
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE - 1);
    localparam logic [TW-1:0] TMO_MAX     = TW'(LOCK_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT - 1);

    state_t         state;
    state_t         state_nxt;
    entry_t         head;
    entry_t         push_entry;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_one_left;
    logic           push;
    logic           pop;
    logic           wr_done;
    logic           go_acc;
    logic           lock_hit;
    logic           tmo_hit;
    logic           ready_en;
    logic [HW-1:0]  hold_cnt;
    logic [SW-1:0]  stable_cnt;
    logic [TW-1:0]  tmo_cnt;

    // Keeps cmd_ready low while reset is asserted; rises one cycle after release.
    always_ff @(posedge mgmt_clk or posedge mgmt_reset) begin
        if (mgmt_reset) ready_en <= 1'b0;
        else            ready_en <= 1'b1;
    end

    assign cmd_ready  = ready_en && (state == ST_IDLE) && !fifo_full;
    assign push       = cmd_valid && cmd_ready;
    assign push_entry = '{addr: cmd_addr, data: cmd_data};
    assign pop        = (state == ST_DRAIN) && !mgmt_waitrequest;
    assign wr_done    = mgmt_write && !mgmt_waitrequest;
    // An entry pushed alongside go counts, so go with an empty-but-pushing FIFO starts.
    assign go_acc     = (state == ST_IDLE) && cmd_go && (!fifo_empty || push);
    assign lock_hit   = (state == ST_LOCKWAIT) && pll_locked && (stable_cnt == STABLE_LAST);
    assign tmo_hit    = (state == ST_LOCKWAIT) && (tmo_cnt >= TMO_LAST);
    assign mgmt_read  = 1'b0;

    pll_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (mgmt_clk),
        .rst        (mgmt_reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .one_left   (fifo_one_left)
    );

    always_ff @(posedge mgmt_clk or posedge mgmt_reset) begin
        if (mgmt_reset) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (go_acc) state_nxt = ST_MODE;
            ST_MODE:     if (wr_done) state_nxt = ST_DRAIN;
            ST_DRAIN:    if (wr_done && fifo_one_left) state_nxt = ST_START;
            ST_START:    if (wr_done) state_nxt = ST_HOLDOFF;
            ST_HOLDOFF:  if (hold_cnt >= HOLD_LAST) state_nxt = ST_LOCKWAIT;
            ST_LOCKWAIT: if (lock_hit || tmo_hit) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Bus outputs decode straight from state so reset drops the write strobe at once.
    always_comb begin
        mgmt_write     = 1'b0;
        mgmt_address   = '0;
        mgmt_writedata = '0;
        busy           = (state != ST_IDLE);
        case (state)
            ST_MODE: begin
                mgmt_write     = 1'b1;
                mgmt_address   = MODE_ADDR;
                mgmt_writedata = MODE_DATA;
            end
            ST_DRAIN: begin
                mgmt_write     = 1'b1;
                mgmt_address   = head.addr;
                mgmt_writedata = head.data;
            end
            ST_START: begin
                mgmt_write     = 1'b1;
                mgmt_address   = START_ADDR;
                mgmt_writedata = START_DATA;
            end
            default: ;
        endcase
    end

    // Timeout counts from start-write completion, through holdoff and lock wait.
    always_ff @(posedge mgmt_clk or posedge mgmt_reset) begin
        if (mgmt_reset) begin
            hold_cnt   <= '0;
            stable_cnt <= '0;
            tmo_cnt    <= '0;
        end else if (state == ST_START && wr_done) begin
            hold_cnt   <= '0;
            stable_cnt <= '0;
            tmo_cnt    <= '0;
        end else if (state == ST_HOLDOFF) begin
            if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HW'(1);
            if (tmo_cnt != TMO_MAX)   tmo_cnt  <= tmo_cnt + TW'(1);
        end else if (state == ST_LOCKWAIT) begin
            if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + TW'(1);
            if (!pll_locked)                  stable_cnt <= '0;
            else if (stable_cnt != STABLE_MAX) stable_cnt <= stable_cnt + SW'(1);
        end
    end

    // Lock beats timeout when both land in the same cycle.
    always_ff @(posedge mgmt_clk or posedge mgmt_reset) begin
        if (mgmt_reset) begin
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            done <= lock_hit;
            if (go_acc)                    error <= 1'b0;
            else if (tmo_hit && !lock_hit) error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq: bus ordering, stalls, lock/timeout, full FIFO, reset abort.
// Latency: n/a.
// Backpressure: bench models a slave stalling a fixed number of cycles per write.
module tb_pll_reconfig_seq;

    logic        mgmt_clk = 1'b0;
    logic        mgmt_reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_go;
    logic        busy;
    logic        done;
    logic        error;
    logic        mgmt_waitrequest;
    logic        mgmt_write;
    logic        mgmt_read;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        pll_locked;

    int checks = 0;
    int errors = 0;

    logic [5:0]  q_addr[$];
    logic [31:0] q_data[$];
    int          q_cyc[$];
    int          done_cyc;
    int          done_cnt;
    int          err_cyc;
    int          busy_fall;
    int          hold_viol;
    int          notready;
    logic        busy_at1;
    logic        err_at1;

    always #5 mgmt_clk = ~mgmt_clk;

    pll_reconfig_seq dut (
        .mgmt_clk         (mgmt_clk),
        .mgmt_reset       (mgmt_reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_addr         (cmd_addr),
        .cmd_data         (cmd_data),
        .cmd_go           (cmd_go),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .mgmt_waitrequest (mgmt_waitrequest),
        .mgmt_write       (mgmt_write),
        .mgmt_read        (mgmt_read),
        .mgmt_address     (mgmt_address),
        .mgmt_writedata   (mgmt_writedata),
        .pll_locked       (pll_locked)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] wa(input int k);
        return (k < q_addr.size()) ? {58'd0, q_addr[k]} : {64{1'bx}};
    endfunction

    function automatic logic [63:0] wd(input int k);
        return (k < q_data.size()) ? {32'd0, q_data[k]} : {64{1'bx}};
    endfunction

    function automatic logic [63:0] wc(input int k);
        return (k < q_cyc.size()) ? 64'(q_cyc[k]) : {64{1'bx}};
    endfunction

    // mode 0: locked, mode 1: never locked, mode 2: 10 high / 1 low from cycle 68, then high.
    function automatic logic lock_fn(input int mode, input int i);
        if (mode == 1) return 1'b0;
        if (mode == 2 && i >= 68 && i < 101) return ((i - 68) % 11) != 10;
        return 1'b1;
    endfunction

    task automatic push(input logic [5:0] a, input logic [31:0] d);
        @(negedge mgmt_clk);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
        #1;
        if (!cmd_ready) notready++;
    endtask

    task automatic end_push();
        @(negedge mgmt_clk);
        cmd_valid = 1'b0;
    endtask

    // Pulses go, then observes one cycle per negedge; cycle 1 is the first cycle after go.
    task automatic run_seq(input int stall, input int lmode, input int budget);
        int sc;
        int tail;
        logic prev_stall;
        logic [5:0] prev_a;
        logic [31:0] prev_d;
        q_addr.delete(); q_data.delete(); q_cyc.delete();
        done_cyc = -1; done_cnt = 0; err_cyc = -1; busy_fall = -1; hold_viol = 0;
        sc = 0; tail = 0; prev_stall = 1'b0; prev_a = '0; prev_d = '0;
        @(negedge mgmt_clk);
        cmd_go = 1'b1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge mgmt_clk);
            cmd_go = 1'b0;
            pll_locked = lock_fn(lmode, i);
            if (mgmt_write && sc < stall) begin
                mgmt_waitrequest = 1'b1;
                sc++;
            end else begin
                mgmt_waitrequest = 1'b0;
                sc = 0;
            end
            #1;
            if (prev_stall && (!mgmt_write || mgmt_address != prev_a || mgmt_writedata != prev_d))
                hold_viol++;
            prev_stall = mgmt_write && mgmt_waitrequest;
            prev_a = mgmt_address;
            prev_d = mgmt_writedata;
            if (mgmt_write && !mgmt_waitrequest) begin
                q_addr.push_back(mgmt_address);
                q_data.push_back(mgmt_writedata);
                q_cyc.push_back(i);
            end
            if (i == 1) begin
                busy_at1 = busy;
                err_at1  = error;
            end
            if (!busy && busy_fall < 0) busy_fall = i;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = i;
            end
            if (error && err_cyc < 0) err_cyc = i;
            if (done_cyc > 0 || err_cyc > 0) tail++;
            if (tail > 3) break;
        end
        mgmt_waitrequest = 1'b0;
    endtask

    logic [5:0]  e_addr[5];
    logic [31:0] e_data[5];
    int          quiet;

    initial begin
        mgmt_reset = 1'b1;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_go = 1'b0;
        mgmt_waitrequest = 1'b0; pll_locked = 1'b1; notready = 0;
        e_addr[0] = 6'h00; e_data[0] = 32'd0;
        e_addr[1] = 6'h04; e_data[1] = 32'h0101;
        e_addr[2] = 6'h05; e_data[2] = 32'h0202;
        e_addr[3] = 6'h08; e_data[3] = 32'h0303;
        e_addr[4] = 6'h02; e_data[4] = 32'd1;

        // Reset state
        @(negedge mgmt_clk); @(negedge mgmt_clk); #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_write", mgmt_write, 0);
        chk("rst_addr", mgmt_address, 0);
        chk("rst_wdata", mgmt_writedata, 0);
        chk("rst_read", mgmt_read, 0);
        @(negedge mgmt_clk);
        mgmt_reset = 1'b0;
        #1 chk("rel_cmd_ready_same", cmd_ready, 0);
        @(negedge mgmt_clk); #1;
        chk("rel_cmd_ready_next", cmd_ready, 1);

        // Test 1: three writes, no stalls, locked throughout
        push(6'h04, 32'h0101); push(6'h05, 32'h0202); push(6'h08, 32'h0303); end_push();
        run_seq(0, 0, 300);
        chk("t1_nwr", q_addr.size(), 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t1_addr%0d", k), wa(k), {58'd0, e_addr[k]});
            chk($sformatf("t1_data%0d", k), wd(k), {32'd0, e_data[k]});
            chk($sformatf("t1_cyc%0d", k), wc(k), 64'(k + 1));
        end
        chk("t1_done_cyc", done_cyc, 86);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_err", err_cyc, -1);
        chk("t1_busy_at1", busy_at1, 1);
        chk("t1_busy_fall", busy_fall, 86);

        // Test 2: each write stalled 3 cycles
        push(6'h04, 32'h0101); push(6'h05, 32'h0202); push(6'h08, 32'h0303); end_push();
        run_seq(3, 0, 300);
        chk("t2_nwr", q_addr.size(), 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t2_addr%0d", k), wa(k), {58'd0, e_addr[k]});
            chk($sformatf("t2_data%0d", k), wd(k), {32'd0, e_data[k]});
            chk($sformatf("t2_cyc%0d", k), wc(k), 64'(4 * (k + 1)));
        end
        chk("t2_hold_stable", hold_viol, 0);
        chk("t2_done_cyc", done_cyc, 101);

        // Test 3: never locks -> timeout 65536 cycles after start-write completion
        push(6'h04, 32'h0101); push(6'h05, 32'h0202); push(6'h08, 32'h0303); end_push();
        run_seq(0, 1, 70000);
        chk("t3_err_cyc", err_cyc, 65542);
        chk("t3_done_cnt", done_cnt, 0);
        chk("t3_busy_fall", busy_fall, 65542);
        pll_locked = 1'b1;

        // Test 4: lock flicker, and the go that clears error
        push(6'h10, 32'hCAFE); end_push();
        #1 chk("t4_err_sticky", error, 1);
        run_seq(0, 2, 400);
        chk("t4_err_cleared", err_at1, 0);
        chk("t4_nwr", q_addr.size(), 3);
        chk("t4_data1", wd(1), 32'hCAFE);
        chk("t4_done_cyc", done_cyc, 117);
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_err", err_cyc, -1);

        // Test 5: fill to 16 entries, refuse the 17th, then drain
        for (int k = 0; k < 16; k++) push(6'(k + 8), 32'hA000 + 32'(k));
        #1 chk("t5_ready_while_filling", notready, 0);
        @(negedge mgmt_clk);
        cmd_addr = 6'h3F; cmd_data = 32'hDEAD;
        #1 chk("t5_ready_full", cmd_ready, 0);
        end_push();
        run_seq(0, 0, 300);
        chk("t5_nwr", q_addr.size(), 18);
        chk("t5_first_entry", wd(1), 32'hA000);
        chk("t5_last_entry", wd(16), 32'hA00F);
        chk("t5_start_addr", wa(17), 6'h02);
        chk("t5_done_cyc", done_cyc, 99);

        // Go with an empty FIFO is ignored
        quiet = 0;
        @(negedge mgmt_clk); cmd_go = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge mgmt_clk);
            cmd_go = 1'b0;
            #1;
            if (busy || mgmt_write || done) quiet++;
        end
        chk("t5_empty_go_quiet", quiet, 0);

        // Test 6: reset while a DRAIN write is stalled
        push(6'h04, 32'h0101); push(6'h05, 32'h0202); end_push();
        @(negedge mgmt_clk); cmd_go = 1'b1;
        @(negedge mgmt_clk); cmd_go = 1'b0;   // cycle 1: mode write completes
        @(negedge mgmt_clk); mgmt_waitrequest = 1'b1;
        #1 chk("t6_drain_addr", mgmt_address, 6'h04);
        @(negedge mgmt_clk); @(negedge mgmt_clk); #1;
        chk("t6_held_write", mgmt_write, 1);
        chk("t6_held_data", mgmt_writedata, 32'h0101);
        #2 mgmt_reset = 1'b1;
        #1;
        chk("t6_write_dropped", mgmt_write, 0);
        chk("t6_busy_reset", busy, 0);
        @(negedge mgmt_clk);
        mgmt_reset = 1'b0;
        mgmt_waitrequest = 1'b0;
        @(negedge mgmt_clk); #1;
        chk("t6_ready_after", cmd_ready, 1);
        cmd_go = 1'b1;
        @(negedge mgmt_clk); cmd_go = 1'b0;
        #1 chk("t6_fifo_empty_go", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
